// File: rtl/morse_serializer.sv
// Timed Morse keyer for decimal digits fed through a small push FIFO.
// Define MORSE_WORD_GAP_EN to append a 4U word gap when the queue runs dry.
module morse_serializer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       ready,
  output logic       cheio,
  output logic       ocupado,
  output logic       erro,
  output logic       sinal,
  output logic [4:0] morse
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef MORSE_WORD_GAP_EN
  localparam int unsigned MAX_UNITS = 4;
`else
  localparam int unsigned MAX_UNITS = 3;
`endif
  localparam int unsigned TMR_W = $clog2(MAX_UNITS * UNIT_CYCLES);

  localparam logic [TMR_W-1:0] T_UNIT = TMR_W'(UNIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_DASH = TMR_W'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [TMR_W-1:0] T_WGAP = TMR_W'(4 * UNIT_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, CHAR_GAP, WORD_GAP} state_e;

  function automatic logic [4:0] encode(input logic [3:0] d);
    case (d)
      4'd1:    encode = 5'b10000;
      4'd2:    encode = 5'b11000;
      4'd3:    encode = 5'b11100;
      4'd4:    encode = 5'b11110;
      4'd5:    encode = 5'b11111;
      4'd6:    encode = 5'b01111;
      4'd7:    encode = 5'b00111;
      4'd8:    encode = 5'b00011;
      4'd9:    encode = 5'b00001;
      default: encode = 5'b00000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       shreg_q, shreg_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       morse_q, morse_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sinal_q, ocupado_q, cheio_q, erro_q;
  logic             sinal_d, ocupado_d, cheio_d, erro_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic             push_ok, pop;
  logic [4:0]       head_pat;

  // Queue storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= num;
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    morse_d  = morse_q;
    pop      = 1'b0;
    head_pat = encode(mem_q[rd_ptr_q]);
    push_ok  = ready && (num <= 4'd9) && (count_q != FULL);

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      MARK: begin
        if (tmr_q == '0) begin
          tmr_d   = (idx_q < 3'd4) ? T_UNIT : T_DASH;
          state_d = (idx_q < 3'd4) ? SPACE : CHAR_GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SPACE: begin
        if (tmr_q == '0) begin
          state_d = MARK;
          idx_d   = idx_q + 3'd1;
          shreg_d = {shreg_q[2:0], 1'b0};
          tmr_d   = shreg_q[3] ? T_UNIT : T_DASH;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      CHAR_GAP: begin
        if (tmr_q == '0) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
`ifdef MORSE_WORD_GAP_EN
            state_d = WORD_GAP;
            tmr_d   = T_WGAP;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
`ifdef MORSE_WORD_GAP_EN
      WORD_GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
`endif
      default: state_d = IDLE;
    endcase

    // A pop always launches the first mark of the head character.
    if (pop) begin
      state_d = MARK;
      morse_d = head_pat;
      shreg_d = head_pat[3:0];
      idx_d   = 3'd0;
      tmr_d   = head_pat[4] ? T_UNIT : T_DASH;
    end

    wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    sinal_d   = (state_d == MARK);
    ocupado_d = (state_d != IDLE) || (count_d != '0);
    cheio_d   = (count_d == FULL);
    erro_d    = ready && !push_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      morse_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sinal_q   <= 1'b0;
      ocupado_q <= 1'b0;
      cheio_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      morse_q   <= morse_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sinal_q   <= sinal_d;
      ocupado_q <= ocupado_d;
      cheio_q   <= cheio_d;
      erro_q    <= erro_d;
    end
  end

  assign sinal   = sinal_q;
  assign ocupado = ocupado_q;
  assign cheio   = cheio_q;
  assign erro    = erro_q;
  assign morse   = morse_q;

endmodule

// File: tb/tb_morse_serializer.sv
// Bench for morse_serializer: queue/waveform model checked every cycle plus directed literals.
module tb_morse_serializer;
  localparam int U = 2;
  localparam int D = 4;
`ifdef MORSE_WORD_GAP_EN
  localparam bit WG = 1'b1;
`else
  localparam bit WG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] num = 4'd0;
  logic       cheio, ocupado, erro, sinal;
  logic [4:0] morse;

  int checks = 0;
  int failures = 0;

  morse_serializer #(.UNIT_CYCLES(U), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .num(num), .ready(ready),
    .cheio(cheio), .ocupado(ocupado), .erro(erro), .sinal(sinal), .morse(morse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Dots in the first d positions for 1..5, dashes shifting in for 6..9.
  function automatic logic [4:0] pattern(input int d);
    logic [4:0] p;
    p = 5'b11111;
    if (d == 0) p = 5'b00000;
    else if (d <= 5) p = p << (5 - d);
    else p = p >> (d - 5);
    return p;
  endfunction

  // Model: digit queue plus the per-cycle sinal waveform still to be emitted.
  int         q[$];
  bit         wave[$];
  bit         pend_wg = 1'b0;
  bit         after_wg = 1'b0;
  logic       exp_sinal = 1'b0, exp_ocup = 1'b0, exp_cheio = 1'b0, exp_erro = 1'b0;
  logic [4:0] exp_morse = 5'b0;

  always @(posedge clk or posedge reset) begin : model
    bit acc, act;
    int n_pre, d;
    logic [4:0] p;
    if (reset) begin
      q.delete(); wave.delete();
      pend_wg = 1'b0; after_wg = 1'b0;
      exp_sinal = 1'b0; exp_ocup = 1'b0; exp_cheio = 1'b0; exp_erro = 1'b0;
      exp_morse = 5'b0;
    end else begin
      n_pre = q.size();
      acc = ready && (num <= 4'd9) && (n_pre < D);
      exp_erro = ready && !acc;
      act = 1'b0;
      exp_sinal = 1'b0;
      if (wave.size() > 0) begin
        exp_sinal = wave.pop_front();
        act = 1'b1;
      end else if (after_wg) begin
        after_wg = 1'b0;
      end else if (n_pre > 0) begin
        d = q.pop_front();
        p = pattern(d);
        exp_morse = p;
        for (int i = 4; i >= 0; i--) begin
          repeat (p[i] ? U : 3 * U) wave.push_back(1'b1);
          repeat (i > 0 ? U : 3 * U) wave.push_back(1'b0);
        end
        exp_sinal = wave.pop_front();
        act = 1'b1;
        pend_wg = WG;
      end else if (pend_wg) begin
        pend_wg = 1'b0;
        repeat (4 * U) wave.push_back(1'b0);
        exp_sinal = wave.pop_front();
        act = 1'b1;
        after_wg = 1'b1;
      end
      if (acc) q.push_back(int'(num));
      exp_ocup = act || (q.size() > 0);
      exp_cheio = (q.size() == D);
    end
  end

  always @(negedge clk) begin : compare
    chk("sinal", int'(sinal), int'(exp_sinal));
    chk("ocupado", int'(ocupado), int'(exp_ocup));
    chk("cheio", int'(cheio), int'(exp_cheio));
    chk("erro", int'(erro), int'(exp_erro));
    chk("morse", int'(morse), int'(exp_morse));
  end

  task automatic cyc(input logic r, input logic [3:0] n);
    @(negedge clk);
    ready = r;
    num = n;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (ocupado !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", int'(t < budget), 1);
  endtask

  int runs[$];
  int tot;
  int rise_t;

  // Latency to first tone, then run lengths of sinal until ocupado drops.
  task automatic run_trace(input int budget);
    logic prev;
    int len;
    runs.delete();
    rise_t = 0;
    while (sinal !== 1'b1 && rise_t < budget) begin
      @(negedge clk);
      rise_t++;
    end
    chk("rise_timeout", int'(rise_t < budget), 1);
    tot = 0; prev = 1'b1; len = 0;
    while (ocupado === 1'b1 && tot < budget) begin
      if (sinal === prev) len++;
      else begin
        runs.push_back(len);
        prev = sinal;
        len = 1;
      end
      @(negedge clk);
      tot++;
    end
    runs.push_back(len);
  endtask

  int exp_runs[10] = '{2, 2, 6, 2, 6, 2, 6, 2, 6, 6};

  initial begin : stim
    int t, highs;
    chk("pat1_lit", int'(pattern(1)), 5'b10000);
    chk("pat6_lit", int'(pattern(6)), 5'b01111);
    repeat (3) @(negedge clk);
    chk("rst_sinal", int'(sinal), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_morse", int'(morse), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single digit 1: latency, full keying pattern, busy duration.
    cyc(1'b1, 4'd1);
    cyc(1'b0, 4'd0);
    run_trace(200);
    chk("t1_latency", rise_t, 1);
    chk("t1_busy_cycles", tot, 40);
    chk("t1_morse", int'(morse), 5'b10000);
    chk("t1_run_count", runs.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t1_run%0d", i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);

    // 5 then 0 back to back: 12U character, no bubble before the dash.
    cyc(1'b1, 4'd5);
    cyc(1'b1, 4'd0);
    cyc(1'b0, 4'd0);
    chk("t2_morse5", int'(morse), 5'b11111);
    t = 0;
    while (morse !== 5'b00000 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t2_char5_len", t, 24);
    chk("t2_dash_start", int'(sinal), 1);
    wait_idle(400);
    repeat (12) @(negedge clk);

    // Out-of-range digit while idle.
    cyc(1'b1, 4'd12);
    cyc(1'b0, 4'd0);
    chk("t4_erro", int'(erro), 1);
    chk("t4_ocupado", int'(ocupado), 0);
    chk("t4_sinal", int'(sinal), 0);
    chk("t4_morse", int'(morse), 5'b00000);
    cyc(1'b0, 4'd0);
    chk("t4_erro_clear", int'(erro), 0);
    repeat (2) @(negedge clk);

    // Six consecutive pushes: fifth fills the queue, sixth is rejected.
    for (int d = 1; d <= 5; d++) cyc(1'b1, 4'(d));
    cyc(1'b1, 4'd6);
    chk("t3_cheio", int'(cheio), 1);
    cyc(1'b0, 4'd0);
    chk("t3_erro", int'(erro), 1);
    cyc(1'b0, 4'd0);
    chk("t3_erro_once", int'(erro), 0);
    wait_idle(1500);
    chk("t3_last_morse", int'(morse), 5'b11111);
    repeat (12) @(negedge clk);

    // Reset during the second dash of digit 1.
    cyc(1'b1, 4'd1);
    cyc(1'b0, 4'd0);
    repeat (15) @(negedge clk);
    chk("t5_in_dash", int'(sinal), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_sinal", int'(sinal), 0);
    chk("t5_async_ocupado", int'(ocupado), 0);
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
    repeat (60) begin
      @(negedge clk);
      if (sinal === 1'b1) highs++;
    end
    chk("t5_no_resume", highs, 0);
    chk("t5_idle", int'(ocupado), 0);

`ifdef MORSE_WORD_GAP_EN
    // Word gap: 14 cycles of silence after the last dot, late push waits it out.
    cyc(1'b1, 4'd5);
    cyc(1'b0, 4'd0);
    run_trace(200);
    chk("wg_tail_low", (runs.size() > 0) ? runs[runs.size() - 1] : -1, 14);
    repeat (4) @(negedge clk);
    cyc(1'b1, 4'd5);
    cyc(1'b0, 4'd0);
    repeat (25) @(negedge clk);
    cyc(1'b1, 4'd7);
    ready = 1'b0;
    t = 0;
    while (sinal !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wg_push_wait", t, 8);
    wait_idle(600);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
